// File: rtl/bec_uart_tx.sv
// rtl/bec_uart_tx.sv - 8N1 UART transmitter with byte FIFO for BEC status output
module bec_uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          io_oeb,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] MIN_P = DIV_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_period;
  logic             r_tx;
  logic             r_done;
  logic             r_oeb;

  logic             w_push;
  logic             w_pop;
  logic             w_cnt_last;
  logic [DIV_W-1:0] w_period;
  logic [7:0]       w_head;

  // in_ready depends only on stored occupancy, so a same-cycle pop never opens a full FIFO
  assign in_ready   = resetb && (r_count != FULL_LVL);
  assign w_push     = in_valid && in_ready;
  assign w_cnt_last = (r_cnt == (r_period - DIV_W'(1)));
  assign w_period   = (clk_div < MIN_P) ? MIN_P : clk_div;
  assign w_head     = r_mem[r_rptr];

  // A new frame may only begin from IDLE or at the last cycle of a stop bit
  assign w_pop = enable && (r_count != '0) &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_cnt_last));

  assign tx         = r_tx;
  assign io_oeb     = r_oeb;
  assign tx_done    = r_done;
  assign fifo_level = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

  // FIFO storage; contents are don't-care until written, so no reset is needed
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // FIFO pointers wrap naturally modulo the power-of-two depth
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - LW'(1);
      end
    end
  end

  // Pad output enable simply follows the transmitter enable one cycle later
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_oeb <= 1'b1;
    end else begin
      r_oeb <= ~enable;
    end
  end

  // Frame sequencer: start, 8 data bits LSB first, stop; tx and tx_done are registered here
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_period <= '0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_head;
            r_period <= w_period;
            r_cnt    <= '0;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        S_STOP: begin
          if (w_cnt_last) begin
            r_done <= 1'b1;
            r_cnt  <= '0;
            if (w_pop) begin
              // back-to-back frame: no idle gap after the stop bit
              r_shift  <= w_head;
              r_period <= w_period;
              r_tx     <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bec_uart_tx.md
Name: bec_uart_tx

Overview:
- Byte-oriented 8N1 UART transmitter in the user project area. Streams BEC status and result bytes out on an mprj_io pad to an external UART receiver (bench tbuart, or a host).
- Sits between the BEC control logic (byte producer, valid/ready) and the GPIO pad (tx data plus active-low output enable).
- Has an internal FIFO so the BEC control logic can burst several bytes without stalling.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the TX FIFO; must be a power of 2, at least 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clock  input  1  system clock; all logic rising-edge.
- resetb  input  1  asynchronous active-low reset.
- enable  input  1  transmitter enable; gates the start of new frames only.
- clk_div  input  DIV_W  bit period in clock cycles; values below 4 are treated as 4.
- in_valid  input  1  producer has a byte.
- in_data  input  8  byte to send.
- in_ready  output  1  FIFO can accept a byte.
- tx  output  1  serial line, idle high.
- io_oeb  output  1  pad output enable, active low.
- busy  output  1  frame in progress or FIFO non-empty.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; the clock port is named clock and the reset port is named resetb.
- Reset values: tx=1, io_oeb=1, in_ready=0 while resetb=0 then 1, busy=0, tx_done=0, fifo_level=0. FIFO pointers cleared, FSM in IDLE, bit and period counters 0.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronous); the partial frame and all FIFO contents are discarded.
- io_oeb: registered as ~enable, updated every cycle.
- Write handshake:
  - A byte is written on a rising edge where in_valid && in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH), decoded from registered state only.
  - When full, in_ready stays 0 even if a pop happens in the same cycle.
  - in_valid with in_ready=0 has no effect; no data is lost or overwritten.
  - A push and a pop in the same cycle leave fifo_level unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If enable=1 and FIFO is non-empty, pop the head byte into the shift register, latch P = max(clk_div,4), go to START.
  - START: tx=0 for P cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for P cycles per bit, LSB first, 8 bits, shifting right after each bit, then go to STOP.
  - STOP: tx=1 for P cycles. On the final cycle tx_done=1 for exactly one cycle. Then:
    - if enable=1 and FIFO is non-empty, pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Latency: a byte written into an empty FIFO on edge N with the FSM in IDLE and enable=1 is popped on edge N+1; tx falls at edge N+1.
- Frame length: exactly 10*P cycles from tx falling to the end of the stop bit.
- clk_div changes mid-frame are ignored; the new value takes effect at the next START.
- enable deasserted mid-frame: the current frame completes normally, then the FSM holds in IDLE. The FIFO keeps accepting writes regardless of enable.
- busy = (state != IDLE) || (fifo_level != 0).
- FIFO read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally modulo FIFO_DEPTH.

Test Plan:
- Reset, enable=1, clk_div=8, write 0xA5: tx low at edge N+1, then bits 1,0,1,0,0,1,0,1 (LSB first), 8 cycles each, stop high. tx_done pulses at cycle 80 after tx fell. busy falls the next cycle.
- clk_div=8, hold in_valid and write 0x30,0xFC,0xAB,0x41,0xFF back-to-back: in_ready drops when fifo_level=4. All 5 bytes arrive in order at a reference receiver with no idle gaps between frames; there are exactly 5 tx_done pulses.
- clk_div=2: the effective bit period is 4 cycles and a frame is 40 cycles. Changing clk_div 8→16 during DATA leaves the current frame at 8 cycles/bit; the next frame uses 16.
- enable=0 with 3 bytes written: tx stays 1, fifo_level=3, busy=1, io_oeb=1. Raise enable: io_oeb=0 next cycle and 3 frames are sent. Drop enable during the 2nd frame: that frame completes, the FSM idles, fifo_level=1.
- Assert resetb=0 during the DATA bit 3 of 0x00: tx=1 with no clock edge. After release: fifo_level=0, busy=0, and a new write of 0x55 transmits correctly.
- Wrap-around: write and drain 9 bytes one at a time (pointers wrap twice). All bytes arrive correct, and fifo_level never exceeds 1.
